inst_axi_rbridge: RTL and testbench

INST_AXI_RBRIDGE -- requirements
Module: inst_axi_rbridge

---
 rtl/inst_axi_rbridge.sv | 124 ++++++++++++
 tb/tb_inst_axi_rbridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rbridge.sv
// Instruction-fetch SRAM-like port to AXI4 read bridge with one outstanding single-beat fetch.
// Define INST_BRIDGE_RDATA_BUF_EN to register returned data and present it one cycle later (RET state).
module inst_axi_rbridge #(
    parameter logic [3:0] ARID_VAL = 4'h0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

`ifdef INST_BRIDGE_RDATA_BUF_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_RET = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2} state_e;
`endif

    state_e      state_q;
    logic [31:0] addr_q;
    logic        beat_hit;
    logic        unused_ok;

    // Beats tagged with a foreign ID are consumed but never answered.
    assign beat_hit = (state_q == S_R) && rvalid && (rid == ARID_VAL);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_sram_req) begin
                        addr_q  <= inst_sram_addr;
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (beat_hit) begin
`ifdef INST_BRIDGE_RDATA_BUF_EN
                        state_q <= S_RET;
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
`ifdef INST_BRIDGE_RDATA_BUF_EN
                S_RET: begin
                    state_q <= S_IDLE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INST_BRIDGE_RDATA_BUF_EN
    logic [31:0] rbuf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_q <= '0;
        end else if (beat_hit) begin
            rbuf_q <= rdata;
        end
    end

    assign inst_sram_data_ok = (state_q == S_RET) && !reset;
    assign inst_sram_rdata   = inst_sram_data_ok ? rbuf_q : '0;
`else
    assign inst_sram_data_ok = beat_hit && !reset;
    assign inst_sram_rdata   = inst_sram_data_ok ? rdata : '0;
`endif

    // NOTE: reset is synchronous, so the decoded handshakes are also masked by reset to stay quiet during the first reset cycle.
    assign inst_sram_addr_ok = inst_sram_req && (state_q == S_IDLE) && !reset;
    assign arvalid           = (state_q == S_AR) && !reset;
    assign rready            = (state_q == S_R) && !reset;

    assign arid    = ARID_VAL;
    assign araddr  = addr_q;
    assign arlen   = 8'h00;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'b000;

    // Fetches are always reads; write fields and response status carry no meaning here.
    assign unused_ok = &{1'b0, inst_sram_wen, inst_sram_wdata, rresp, rlast};

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Scoreboard bench for inst_axi_rbridge: the bench plays IF stage and AXI slave, a monitor checks returned data.
module tb_inst_axi_rbridge;

    localparam logic [3:0] ARID = 4'h5;
`ifdef INST_BRIDGE_RDATA_BUF_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    inst_axi_rbridge #(.ARID_VAL(ARID)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dok_count = 0;
    int dok_cyc  = 0;
    int ao_cyc   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Instruction memory: explicit words where stored, otherwise a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], a[31:16]} ^ 32'hc3a5_5a3c;
    endfunction

    always @(negedge clk) begin
        if (!reset && inst_sram_data_ok === 1'b1) begin
            dok_count++;
            dok_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_data_ok", {31'b0, inst_sram_data_ok}, 32'h0);
            end else begin
                exp_w = exp_q.pop_front();
                check("fetch_rdata", inst_sram_rdata, exp_w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        bit quiet;
        quiet = 1'b1;
        reset = 1'b1;
        inst_sram_req = 1'b1;
        inst_sram_addr = $urandom;
        arready = 1'b1;
        rvalid = 1'b1;
        rid = ARID;
        rdata = $urandom;
        for (int n = 0; n < cycles; n++) begin
            tick();
            #1;
            if ({inst_sram_addr_ok, inst_sram_data_ok, arvalid, rready} !== 4'b0 ||
                inst_sram_rdata !== 32'h0 || araddr !== 32'h0) quiet = 1'b0;
        end
        check("reset_outputs_zero", {31'b0, quiet}, 32'h1);
        reset = 1'b0;
        inst_sram_req = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
    endtask

    // One fetch: IF request, then AXI slave behaviour with the given stalls and foreign-ID beats.
    task automatic fetch(input logic [31:0] a, input int ar_dly, input int r_dly,
                         input int junk, input bit abort, output int waited);
        bit ar_stable;
        bit busy_quiet;
        bit rready_ok;
        int d0;
        logic [31:0] want;
        want = mem_word(a);
        inst_sram_req = 1'b1;
        inst_sram_addr = a;
        inst_sram_wen = 4'($urandom);
        inst_sram_wdata = $urandom;
        #1;
        waited = 0;
        while (inst_sram_addr_ok !== 1'b1 && waited < 16) begin
            tick();
            waited++;
            #1;
        end
        if (inst_sram_addr_ok !== 1'b1) begin
            check("addr_ok_timeout", {31'b0, inst_sram_addr_ok}, 32'h1);
            inst_sram_req = 1'b0;
            return;
        end
        exp_q.push_back(want);
        ao_cyc = cyc;
        d0 = dok_count;
        ar_stable = 1'b1;
        busy_quiet = 1'b1;
        rready_ok = 1'b1;
        tick();
        inst_sram_addr = $urandom;
        inst_sram_wen = 4'($urandom);
        for (int n = 0; n < ar_dly; n++) begin
            arready = 1'b0;
            #1;
            if (arvalid !== 1'b1 || araddr !== a) ar_stable = 1'b0;
            if (inst_sram_addr_ok !== 1'b0 || rready !== 1'b0) busy_quiet = 1'b0;
            tick();
        end
        arready = 1'b1;
        #1;
        if (inst_sram_addr_ok !== 1'b0) busy_quiet = 1'b0;
        check("arvalid", {31'b0, arvalid}, 32'h1);
        check("araddr", araddr, a);
        check("ar_constants", {6'b0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
              {6'b0, ARID, 8'h00, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
        if (ar_dly > 0) check("ar_stable_while_stalled", {31'b0, ar_stable}, 32'h1);
        tick();
        arready = 1'b0;
        for (int n = 0; n < r_dly + junk; n++) begin
            rvalid = (n >= r_dly);
            rid = (n == r_dly) ? 4'h3 : (ARID ^ 4'($urandom_range(1, 15)));
            rdata = $urandom;
            #1;
            if (inst_sram_addr_ok !== 1'b0) busy_quiet = 1'b0;
            if (rready !== 1'b1) rready_ok = 1'b0;
            tick();
        end
        if (abort) begin
            rvalid = 1'b0;
            #1;
            check("rready_before_reset", {31'b0, rready}, 32'h1);
            reset = 1'b1;
            tick();
            #1;
            check("ctrl_after_reset_in_R",
                  {28'b0, inst_sram_addr_ok, inst_sram_data_ok, arvalid, rready}, 32'h0);
            check("rdata_after_reset_in_R", inst_sram_rdata, 32'h0);
            check("araddr_after_reset_in_R", araddr, 32'h0);
            void'(exp_q.pop_back());
            inst_sram_req = 1'b0;
            return;
        end
        rvalid = 1'b1;
        rid = ARID;
        rdata = want;
        rresp = 2'($urandom);
        rlast = 1'($urandom);
        #1;
        if (inst_sram_addr_ok !== 1'b0) busy_quiet = 1'b0;
        check("rready", {31'b0, rready}, 32'h1);
        check("no_early_data_ok", dok_count, d0);
        check("no_addr_ok_while_busy", {31'b0, busy_quiet}, 32'h1);
        if (r_dly + junk > 0) check("rready_held_in_R", {31'b0, rready_ok}, 32'h1);
        tick();
        rvalid = 1'b0;
        rid = 4'h0;
        rdata = $urandom;
        inst_sram_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        int d0;
        bit rr;
        reset = 1'b1;
        inst_sram_req = 1'b0;
        inst_sram_wen = 4'h0;
        inst_sram_addr = 32'h0;
        inst_sram_wdata = 32'h0;
        arready = 1'b0;
        rid = 4'h0;
        rdata = 32'h0;
        rresp = 2'b00;
        rlast = 1'b0;
        rvalid = 1'b0;
        mem[32'h1fc0_0000] = 32'h2401_0001;
        mem[32'h0000_3000] = 32'hdead_beef;

        apply_reset(3);

        // Minimum-latency fetch issued in the first cycle after reset.
        fetch(32'h1fc0_0000, 0, 0, 0, 1'b0, waited);
        check("addr_ok_first_cycle_after_reset", waited, 32'h0);
        repeat (3) tick();
        check("fetch_latency", dok_cyc - ao_cyc, LAT);

        // AR channel stalled five cycles.
        fetch(32'h0000_2000, 5, 0, 0, 1'b0, waited);
        repeat (2) tick();

        // Foreign-ID beat before the real one.
        fetch(32'h0000_3000, 1, 1, 1, 1'b0, waited);
        repeat (2) tick();

        // Reset while waiting in R, then a stray beat with no request outstanding.
        fetch(32'h4444_0000, 0, 1, 0, 1'b1, waited);
        reset = 1'b0;
        inst_sram_req = 1'b0;
        d0 = dok_count;
        rr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            rvalid = 1'b1;
            rid = ARID;
            rdata = $urandom;
            #1;
            if (rready !== 1'b0) rr = 1'b1;
            tick();
        end
        rvalid = 1'b0;
        repeat (2) tick();
        check("no_data_ok_after_abort", dok_count, d0);
        check("rready_low_in_idle", {31'b0, rr}, 32'h0);

        apply_reset(2);
        fetch($urandom, 0, 0, 0, 1'b0, waited);
        check("addr_ok_after_second_reset", waited, 32'h0);
        repeat (3) tick();

        // Back-to-back random fetches.
        d0 = dok_count;
        for (int i = 0; i < 100; i++) begin
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, waited);
        end
        repeat (4) tick();
        check("random_data_ok_count", dok_count - d0, 32'd100);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
